// File: rtl/imem_pkg.sv
// Shared types for the loadable instruction memory: instruction word type,
// the canonical NOP used for reset/fill/fault responses, and loader FSM states.
// No logic; imported by imem_byte_loader and imem_loadable.
package imem_pkg;

    typedef logic [31:0] instr_t;

    // ADDI x0,x0,0
    localparam instr_t INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ldr_state_e;

endpackage

// File: rtl/imem_byte_loader.sv
// Purpose : byte-stream program loader; packs little-endian bytes into words
//           and drives the write port of the instruction array.
// Latency : a word is written on the same edge that accepts its final byte
//           (lane 3 or prog_last).
// Backpr. : prog_ready_o is high only in LOAD; offered bytes are otherwise refused.
// Ports   : load_start_i/prog_* in from the loader side; prog_ready_o,
//           load_busy_o, load_done_o, load_words_o out; fetch_block_o tells the
//           fetch path to drop requests; mem_we_o/mem_waddr_o/mem_wdata_o
//           form the array write port.
module imem_byte_loader
    import imem_pkg::*;
#(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start_i,
    input  logic              prog_valid_i,
    input  logic [7:0]        prog_byte_i,
    input  logic              prog_last_i,
    output logic              prog_ready_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   load_words_o,
    output logic              fetch_block_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output instr_t            mem_wdata_o
);

    localparam logic [ADDR_W-1:0] LAST_WPTR = ADDR_W'(MEM_DEPTH - 1);

    ldr_state_e        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    instr_t            asm_q, asm_d;
    logic [ADDR_W:0]   words_q, words_d;

    instr_t            merged;
    logic              byte_acc;
    logic              word_wr;

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        wptr_d   = wptr_q;
        asm_d    = asm_q;
        words_d  = words_q;

        // Lanes above the current one are still zero in asm_q, so a word
        // closed early by prog_last is naturally zero-padded.
        merged   = asm_q | (instr_t'(prog_byte_i) << {lane_q, 3'b000});
        byte_acc = (state_q == LOAD) && prog_valid_i;
        word_wr  = byte_acc && ((lane_q == 2'd3) || prog_last_i);

        unique case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d = LOAD;
                    lane_d  = '0;
                    wptr_d  = '0;
                    asm_d   = '0;
                    words_d = '0;
                end
            end
            LOAD: begin
                // load_start is deliberately not looked at here: a restart
                // request mid-stream is ignored.
                if (byte_acc) begin
                    if (word_wr) begin
                        lane_d  = '0;
                        asm_d   = '0;
                        wptr_d  = wptr_q + ADDR_W'(1);
                        words_d = words_q + (ADDR_W + 1)'(1);
                        // Stop at the end of the image or when the array is full,
                        // so no byte past the last word is ever accepted.
                        if (prog_last_i || (wptr_q == LAST_WPTR)) begin
                            state_d = DONE;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                        asm_d  = merged;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Aborting a load drops any half-built word; the array keeps
            // whatever complete words were already written.
            state_q <= IDLE;
            lane_q  <= '0;
            wptr_q  <= '0;
            asm_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wptr_q  <= wptr_d;
            asm_q   <= asm_d;
            words_q <= words_d;
        end
    end

    assign prog_ready_o  = (state_q == LOAD);
    assign load_busy_o   = (state_q == LOAD);
    assign load_done_o   = (state_q == DONE);
    assign load_words_o  = words_q;
    // A load_start accepted this cycle wins over a simultaneous fetch.
    assign fetch_block_o = (state_q == LOAD) || ((state_q == IDLE) && load_start_i);
    assign mem_we_o      = word_wr;
    assign mem_waddr_o   = wptr_q;
    assign mem_wdata_o   = merged;

endmodule

// File: rtl/imem_loadable.sv
// Purpose : instruction memory for the IF stage with run-time reloadable
//           contents, misaligned/out-of-range fault flag and fetch stall.
// Latency : READ_LAT register stages (1 or 2) from request to fetch_instr.
// Backpr. : fetch_stall freezes every fetch stage; fetch_req is dropped while
//           the loader is busy, and the in-flight pipeline is flushed.
// Ports   : clk/rst; fetch_req/fetch_addr/fetch_stall in, fetch_instr/
//           fetch_valid/fetch_fault out; load_start/prog_valid/prog_byte/
//           prog_last in, prog_ready/load_busy/load_done/load_words out.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int     INSTR_W     = 32,
    parameter int     MEM_DEPTH   = 128,
    parameter int     ADDR_W      = $clog2(MEM_DEPTH),
    parameter int     PC_W        = 32,
    parameter int     READ_LAT    = 1,
    parameter instr_t RESET_INSTR = INSTR_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [PC_W-1:0]    fetch_addr,
    input  logic               fetch_stall,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_valid,
    output logic               fetch_fault,
    input  logic               load_start,
    input  logic               prog_valid,
    input  logic [7:0]         prog_byte,
    input  logic               prog_last,
    output logic               prog_ready,
    output logic               load_busy,
    output logic               load_done,
    output logic [ADDR_W:0]    load_words
);

    // Power-up image is all NOPs; reset never touches the array.
    logic [INSTR_W-1:0] mem_q [MEM_DEPTH] = '{default: RESET_INSTR};

    logic               fetch_block;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    instr_t             mem_wdata;

    imem_byte_loader #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_loader (
        .clk           (clk),
        .rst           (rst),
        .load_start_i  (load_start),
        .prog_valid_i  (prog_valid),
        .prog_byte_i   (prog_byte),
        .prog_last_i   (prog_last),
        .prog_ready_o  (prog_ready),
        .load_busy_o   (load_busy),
        .load_done_o   (load_done),
        .load_words_o  (load_words),
        .fetch_block_o (fetch_block),
        .mem_we_o      (mem_we),
        .mem_waddr_o   (mem_waddr),
        .mem_wdata_o   (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Fault decode on the raw byte address: any upper bit set beyond the
    // array counts as out of range, not just the bits used for indexing.
    logic              addr_fault;
    logic [ADDR_W-1:0] addr_idx;
    logic              req_acc;

    assign addr_idx   = fetch_addr[ADDR_W+1:2];
    assign addr_fault = (fetch_addr[1:0] != 2'b00) ||
                        (fetch_addr[PC_W-1:2] >= (PC_W - 2)'(MEM_DEPTH));
    assign req_acc    = fetch_req && !fetch_block;

    // Read-stage inputs: straight from the request for READ_LAT=1, or from an
    // address register for READ_LAT=2 (any other value builds the 2-stage form).
    logic              rd_vld;
    logic              rd_fault;
    logic [ADDR_W-1:0] rd_idx;

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rd_vld   = req_acc;
            assign rd_fault = addr_fault;
            assign rd_idx   = addr_idx;
        end else begin : g_lat2
            logic              a_vld_q;
            logic              a_fault_q;
            logic [ADDR_W-1:0] a_idx_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_vld_q   <= 1'b0;
                    a_fault_q <= 1'b0;
                    a_idx_q   <= '0;
                end else if (load_busy) begin
                    a_vld_q   <= 1'b0;
                end else if (!fetch_stall) begin
                    a_vld_q   <= req_acc;
                    a_fault_q <= addr_fault;
                    a_idx_q   <= addr_idx;
                end
            end

            assign rd_vld   = a_vld_q;
            assign rd_fault = a_fault_q;
            assign rd_idx   = a_idx_q;
        end
    endgenerate

    logic [INSTR_W-1:0] instr_q;
    logic               vld_q;
    logic               fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= RESET_INSTR;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
        end else if (load_busy) begin
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
        end else if (!fetch_stall) begin
            vld_q   <= rd_vld;
            fault_q <= rd_vld && rd_fault;
            // Idle cycles leave the last instruction on the bus.
            if (rd_vld) begin
                instr_q <= rd_fault ? RESET_INSTR : mem_q[rd_idx];
            end
        end
    end

    // Gating covers the first LOAD cycle, before the flush has reached vld_q.
    assign fetch_instr = instr_q;
    assign fetch_valid = vld_q && !load_busy;
    assign fetch_fault = fault_q && !load_busy;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

    localparam int          DEPTH = 128;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic        fetch_fault;
    logic        load_start;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_last;
    logic        prog_ready;
    logic        load_busy;
    logic        load_done;
    logic [7:0]  load_words;

    imem_loadable #(
        .MEM_DEPTH (DEPTH),
        .READ_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_instr (fetch_instr),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault),
        .load_start  (load_start),
        .prog_valid  (prog_valid),
        .prog_byte   (prog_byte),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_words  (load_words)
    );

    always #5 clk = ~clk;

    // Reference model: program image as a plain word array.
    logic [31:0] mem_m [DEPTH];
    int          ncmp = 0;
    int          nfail = 0;
    int          ecnt = 0;
    logic [31:0] due_i [int];
    logic        due_f [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    function automatic logic m_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (m_fault(a)) return NOP;
        return mem_m[idx];
    endfunction

    // Word w = bytes 4w..4w+3, little-endian; a trailing partial word only
    // lands in memory when it was closed by prog_last.
    function automatic void model_apply(input bq_t img, input int nbytes, input bit keep_partial);
        logic [31:0] v;
        for (int w = 0; w < DEPTH; w++) begin
            if (4 * w >= nbytes) break;
            if ((4 * w + 4 <= nbytes) || keep_partial) begin
                v = '0;
                for (int b = 0; b < 4; b++)
                    if (4 * w + b < nbytes) v[8*b +: 8] = img[4*w+b];
                mem_m[w] = v;
            end
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 4 * DEPTH - 1)) | 32'h1);
        if (r == 1) return 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
        if (r < 5)  return 32'(4 * $urandom_range(0, 3));
        return 32'(4 * $urandom_range(0, DEPTH - 1));
    endfunction

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] ei,
                             input logic ef, input string tag);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        step();
        fetch_req  = 1'b0;
        repeat (LAT - 1) step();
        chk({tag, "_vld"}, 32'(fetch_valid), 32'd1);
        chk({tag, "_instr"}, fetch_instr, ei);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'(ef));
        step();
        chk({tag, "_vld_off"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_hold"}, fetch_instr, ei);
    endtask

    task automatic load_image(input bq_t img, input bit with_last, input bit gaps,
                              input bit with_fetch, input string tag);
        int idx = 0;
        int acc = 0;
        int dones = 0;
        int guard = 0;
        bit last_acc = 0;
        bit rdy_exp;
        int exp_words;
        load_start = 1'b1;
        fetch_req  = with_fetch;
        fetch_addr = 32'h0;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        if (load_done) dones++;
        chk({tag, "_busy"}, 32'(load_busy), 32'd1);
        while (idx < img.size() && guard < 4000) begin
            guard++;
            load_start = (idx == 2);
            if (gaps && $urandom_range(0, 3) == 0) begin
                prog_valid = 1'b0;
            end else begin
                prog_valid = 1'b1;
                prog_byte  = img[idx];
                prog_last  = with_last && (idx == img.size() - 1);
                rdy_exp    = (acc < 4 * DEPTH) && !last_acc;
                chk({tag, "_ready"}, 32'(prog_ready), 32'(rdy_exp));
                if (rdy_exp) begin
                    acc++;
                    if (prog_last) last_acc = 1'b1;
                end
                idx++;
            end
            step();
            load_start = 1'b0;
            prog_valid = 1'b0;
            prog_last  = 1'b0;
            if (load_done) dones++;
            chk({tag, "_nofetch"}, 32'(fetch_valid), 32'd0);
        end
        chk({tag, "_consumed"}, idx, img.size());
        repeat (3) begin
            step();
            if (load_done) dones++;
        end
        exp_words = last_acc ? (acc + 3) / 4 : acc / 4;
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_idle_busy"}, 32'(load_busy), 32'd0);
        chk({tag, "_idle_ready"}, 32'(prog_ready), 32'd0);
        chk({tag, "_words"}, 32'(load_words), exp_words);
        model_apply(img, acc, last_acc);
    endtask

    // Random request stream; each accepted request must show up LAT edges later.
    task automatic fetch_stream(input int n, input string tag);
        bit          have_last = 0;
        logic [31:0] last_i = '0;
        due_i.delete();
        due_f.delete();
        for (int c = 0; c < n + LAT + 1; c++) begin
            if (c < n && $urandom_range(0, 3) != 0) begin
                fetch_req  = 1'b1;
                fetch_addr = rand_addr();
                due_i[ecnt + LAT] = m_instr(fetch_addr);
                due_f[ecnt + LAT] = m_fault(fetch_addr);
            end else begin
                fetch_req = 1'b0;
            end
            step();
            fetch_req = 1'b0;
            if (due_i.exists(ecnt)) begin
                chk({tag, "_vld"}, 32'(fetch_valid), 32'd1);
                chk({tag, "_instr"}, fetch_instr, due_i[ecnt]);
                chk({tag, "_fault"}, 32'(fetch_fault), 32'(due_f[ecnt]));
                last_i    = due_i[ecnt];
                have_last = 1'b1;
            end else begin
                chk({tag, "_idle"}, 32'(fetch_valid), 32'd0);
                if (have_last) chk({tag, "_hold"}, fetch_instr, last_i);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t img;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
        load_start = 1'b0; prog_valid = 1'b0; prog_byte = '0; prog_last = 1'b0;

        // T1 reset
        repeat (3) step();
        rst = 1'b0;
        chk("t1_instr", fetch_instr, NOP);
        chk("t1_vld", 32'(fetch_valid), 32'd0);
        chk("t1_fault", 32'(fetch_fault), 32'd0);
        chk("t1_busy", 32'(load_busy), 32'd0);
        chk("t1_ready", 32'(prog_ready), 32'd0);
        chk("t1_done", 32'(load_done), 32'd0);
        chk("t1_words", 32'(load_words), 32'd0);
        fetch_one(32'h8, NOP, 1'b0, "t1_fill");

        // T2 load of two words, with a fetch colliding with load_start
        img = '{8'h13, 8'h01, 8'h01, 8'hFE, 8'h93, 8'h00, 8'h00, 8'h00};
        load_image(img, 1'b1, 1'b0, 1'b1, "t2");
        fetch_one(32'h0, 32'hFE01_0113, 1'b0, "t2_w0");
        fetch_one(32'h4, 32'h0000_0093, 1'b0, "t2_w1");

        // T3 back-to-back requests, then a 3-cycle stall with req held high
        fetch_req = 1'b1; fetch_addr = 32'h0; step();
        chk("t3_lat", 32'(fetch_valid), 32'd0);
        fetch_addr = 32'h4; step();
        chk("t3_r0_vld", 32'(fetch_valid), 32'd1);
        chk("t3_r0", fetch_instr, 32'hFE01_0113);
        fetch_addr = 32'h8; step();
        chk("t3_r1_vld", 32'(fetch_valid), 32'd1);
        chk("t3_r1", fetch_instr, 32'h0000_0093);
        fetch_stall = 1'b1; fetch_addr = 32'hC;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("t3_stall_vld", 32'(fetch_valid), 32'd1);
            chk("t3_stall_instr", fetch_instr, 32'h0000_0093);
        end
        fetch_stall = 1'b0; fetch_req = 1'b0; step();
        chk("t3_r2_vld", 32'(fetch_valid), 32'd1);
        chk("t3_r2", fetch_instr, m_instr(32'h8));
        step();
        chk("t3_drain_vld", 32'(fetch_valid), 32'd0);
        chk("t3_drain_hold", fetch_instr, m_instr(32'h8));

        // T4 faults and the range boundary
        fetch_one(32'h6, NOP, 1'b1, "t4_misal");
        fetch_one(32'(4 * DEPTH), NOP, 1'b1, "t4_oor");
        fetch_one(32'(4 * (DEPTH - 1)), m_instr(32'(4 * (DEPTH - 1))), 1'b0, "t4_top");
        fetch_one(32'h8000_0000, NOP, 1'b1, "t4_high");

        // T5 overflow: 4*DEPTH+3 bytes, last flag on a byte that never fits
        img.delete();
        for (int i = 0; i < 4 * DEPTH + 3; i++) img.push_back(8'($urandom));
        load_image(img, 1'b1, 1'b0, 1'b0, "t5_ovf");
        fetch_one(32'(4 * (DEPTH - 1)), m_instr(32'(4 * (DEPTH - 1))), 1'b0, "t5_last");
        fetch_one(32'h100, m_instr(32'h100), 1'b0, "t5_mid");

        // T5 partial trailing word
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        load_image(img, 1'b1, 1'b1, 1'b0, "t5_part");
        fetch_one(32'h0, 32'h4433_2211, 1'b0, "t5_p0");
        fetch_one(32'h4, 32'h0000_0055, 1'b0, "t5_p1");
        fetch_one(32'h8, m_instr(32'h8), 1'b0, "t5_p2");

        // T6 reset after 6 bytes aborts the load
        img.delete();
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom_range(1, 255)));
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prog_valid = 1'b1; prog_byte = img[i]; step();
        end
        prog_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        chk("t6_busy", 32'(load_busy), 32'd0);
        chk("t6_ready", 32'(prog_ready), 32'd0);
        chk("t6_done", 32'(load_done), 32'd0);
        chk("t6_words", 32'(load_words), 32'd0);
        chk("t6_instr", fetch_instr, NOP);
        model_apply(img, 6, 1'b0);
        fetch_one(32'h0, m_instr(32'h0), 1'b0, "t6_w0");
        fetch_one(32'h4, 32'h0000_0055, 1'b0, "t6_w1_old");

        // Randomized reloads interleaved with random fetch traffic
        for (int it = 0; it < 6; it++) begin
            img.delete();
            for (int i = 0; i < $urandom_range(1, 14); i++) img.push_back(8'($urandom));
            load_image(img, 1'b1, 1'b1, 1'($urandom_range(0, 1)), "rnd_load");
            fetch_stream(40, "rnd_fetch");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
